// File: rtl/motoro3_step_pwm_gen.sv
// Six-step commutation gate driver for a 3-phase motor: a step timer walks the
// commutation table, and a PWM counter chops the active high-side switch with dead time.
module motoro3_step_pwm_gen #(
    parameter int unsigned DEAD_CLK  = 4,
    parameter logic [24:0] SPEED_MIN = 25'd8
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [24:0] m3r_stepCNT_speedSET,
    input  logic [7:0]  m3r_power_percent,
    input  logic [11:0] m3r_pwmLenWant,
    input  logic [11:0] m3r_pwmMinMask,
    input  logic        m3_enable,
    output logic        m3_uH,
    output logic        m3_uL,
    output logic        m3_vH,
    output logic        m3_vL,
    output logic        m3_wH,
    output logic        m3_wL,
    output logic [2:0]  m3_stepIdx,
    output logic        m3_stepPulse
);

    localparam int unsigned DW = $clog2(DEAD_CLK + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [24:0]   step_q, step_d;
    logic [2:0]    idx_q, idx_d;
    logic          pulse_q, pulse_d;
    logic [11:0]   pwm_q, pwm_d;
    logic [11:0]   len_q, len_d;
    logic [11:0]   on_q, on_d;
    logic [5:0]    gate_q, gate_d;

    logic [24:0]   speed_l;
    logic [11:0]   len_l;
    logic [11:0]   prod;
    logic [11:0]   on_calc;
    logic          tc;
    logic          hi_on;

    assign speed_l = (m3r_stepCNT_speedSET < SPEED_MIN) ? SPEED_MIN : m3r_stepCNT_speedSET;
    assign len_l   = (m3r_pwmLenWant < 12'd2) ? 12'd2 : m3r_pwmLenWant;
    assign prod    = 12'((20'(len_l) * 20'(m3r_power_percent)) >> 8);

    // A mask of half the period or more leaves no room for both a minimum pulse and gap.
    always_comb begin
        on_calc = prod;
        if (m3r_pwmMinMask != 12'd0) begin
            if ((m3r_pwmMinMask >= (len_l >> 1)) || (prod < m3r_pwmMinMask)) begin
                on_calc = '0;
            end else if (prod > (len_l - m3r_pwmMinMask)) begin
                on_calc = len_l - m3r_pwmMinMask;
            end
        end
    end

    assign tc = (state_q != ST_IDLE) && (step_q == 25'd1);

    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        step_d  = step_q;
        idx_d   = idx_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m3_enable) begin
                    state_d = ST_DEAD;
                    dead_d  = '0;
                    step_d  = speed_l;
                end
            end
            ST_DEAD, ST_RUN: begin
                if (tc) begin
                    state_d = ST_DEAD;
                    dead_d  = '0;
                    step_d  = speed_l;
                    idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                    pulse_d = 1'b1;
                end else begin
                    step_d = step_q - 25'd1;
                    if (state_q == ST_DEAD) begin
                        if (dead_q == DW'(DEAD_CLK - 1)) begin
                            state_d = ST_RUN;
                        end else begin
                            dead_d = dead_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!m3_enable) begin
            state_d = ST_IDLE;
            dead_d  = '0;
            step_d  = '0;
            idx_d   = '0;
            pulse_d = 1'b0;
        end
    end

    // Period settings are latched on every edge that lands the counter on 0.
    always_comb begin
        pwm_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            pwm_d = (pwm_q >= len_q - 12'd1) ? 12'd0 : pwm_q + 12'd1;
        end
        len_d = len_q;
        on_d  = on_q;
        if (pwm_d == 12'd0) begin
            len_d = len_l;
            on_d  = on_calc;
        end
    end

    assign hi_on = (pwm_q < on_q);

    // gate bit order: {uH, uL, vH, vL, wH, wL}
    always_comb begin
        gate_d = '0;
        if ((state_q == ST_RUN) && m3_enable) begin
            case (idx_q)
                3'd0: gate_d = {hi_on, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
                3'd1: gate_d = {hi_on, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
                3'd2: gate_d = {1'b0, 1'b0, hi_on, 1'b0, 1'b0, 1'b1};
                3'd3: gate_d = {1'b0, 1'b1, hi_on, 1'b0, 1'b0, 1'b0};
                3'd4: gate_d = {1'b0, 1'b1, 1'b0, 1'b0, hi_on, 1'b0};
                3'd5: gate_d = {1'b0, 1'b0, 1'b0, 1'b1, hi_on, 1'b0};
                default: gate_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= ST_IDLE;
            dead_q  <= '0;
            step_q  <= '0;
            idx_q   <= '0;
            pulse_q <= 1'b0;
            pwm_q   <= '0;
            len_q   <= '0;
            on_q    <= '0;
            gate_q  <= '0;
        end else begin
            state_q <= state_d;
            dead_q  <= dead_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            pulse_q <= pulse_d;
            pwm_q   <= pwm_d;
            len_q   <= len_d;
            on_q    <= on_d;
            gate_q  <= gate_d;
        end
    end

    assign {m3_uH, m3_uL, m3_vH, m3_vL, m3_wH, m3_wL} = gate_q;
    assign m3_stepIdx   = idx_q;
    assign m3_stepPulse = pulse_q;

endmodule

// File: tb/tb_motoro3_step_pwm_gen.sv
// Randomized bench for motoro3_step_pwm_gen: a timeline model predicts every output
// word per clock into a queue, and a negedge monitor pops and compares.
module tb_motoro3_step_pwm_gen;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic [24:0] speed = 25'd16667;
    logic [7:0]  power = 8'h10;
    logic [11:0] len_w = 12'd512;
    logic [11:0] mask = 12'd32;
    logic        en = 1'b1;
    logic        uH, uL, vH, vL, wH, wL;
    logic [2:0]  step_idx;
    logic        step_pulse;

    int compared = 0;
    int mismatched = 0;

    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    motoro3_step_pwm_gen dut (
        .clk                  (clk),
        .nRst                 (nRst),
        .m3r_stepCNT_speedSET (speed),
        .m3r_power_percent    (power),
        .m3r_pwmLenWant       (len_w),
        .m3r_pwmMinMask       (mask),
        .m3_enable            (en),
        .m3_uH                (uH),
        .m3_uL                (uL),
        .m3_vH                (vH),
        .m3_vL                (vL),
        .m3_wH                (wH),
        .m3_wL                (wL),
        .m3_stepIdx           (step_idx),
        .m3_stepPulse         (step_pulse)
    );

    function automatic logic [9:0] act_word();
        return {uH, uL, vH, vL, wH, wL, step_idx, step_pulse};
    endfunction

    function automatic int calc_on(int lw, int pw, int mk);
        int l, p;
        l = (lw < 2) ? 2 : lw;
        p = ((l * pw) % (1 << 20)) / 256;
        if (mk == 0) return p;
        if (mk >= l / 2) return 0;
        if (p < mk) return 0;
        if (p > l - mk) return l - mk;
        return p;
    endfunction

    // Phases: 0=U, 1=V, 2=W. Word bits {uH,uL,vH,vL,wH,wL}.
    function automatic logic [5:0] gates_for(int step, bit hi);
        int hi_ph[6] = '{0, 0, 1, 1, 2, 2};
        int lo_ph[6] = '{1, 2, 2, 0, 0, 1};
        logic [5:0] g;
        g = '0;
        g[5 - 2 * hi_ph[step]] = hi;
        g[4 - 2 * lo_ph[step]] = 1'b1;
        return g;
    endfunction

    // Reference model: absolute cycle numbers, step windows of speedL cycles,
    // first DEAD_CLK cycles of each window dark, PWM periods start after the dark part.
    int  m_cyc = 0;
    bit  m_running = 0;
    int  m_step_start, m_speed, m_idx = 0;
    int  m_per_start, m_per_len, m_per_on;

    initial begin
        forever begin
            @(posedge clk or negedge nRst);
            if (!nRst) begin
                m_running = 0;
                m_idx = 0;
                exp_q.delete();
            end else begin
                logic [5:0] g;
                bit pulse;
                int o, o2;
                m_cyc++;
                g = '0;
                pulse = 0;
                if (!en) begin
                    m_running = 0;
                    m_idx = 0;
                end else if (!m_running) begin
                    m_running = 1;
                    m_step_start = m_cyc;
                    m_speed = (speed < 8) ? 8 : int'(speed);
                end else begin
                    o = m_cyc - 1 - m_step_start;
                    if (o >= 4) g = gates_for(m_idx, (m_cyc - 1 - m_per_start) < m_per_on);
                    if (m_cyc - m_step_start == m_speed) begin
                        m_idx = (m_idx + 1) % 6;
                        pulse = 1;
                        m_step_start = m_cyc;
                        m_speed = (speed < 8) ? 8 : int'(speed);
                    end
                    o2 = m_cyc - m_step_start;
                    if (o2 == 4 || (o2 > 4 && m_cyc - m_per_start == m_per_len)) begin
                        m_per_start = m_cyc;
                        m_per_len = (len_w < 2) ? 2 : int'(len_w);
                        m_per_on = calc_on(int'(len_w), int'(power), int'(mask));
                    end
                end
                exp_q.push_back({g, 3'(m_idx), pulse});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            compared++;
            if ((uH && uL) || (vH && vL) || (wH && wL)) begin
                mismatched++;
                $display("FAIL shoot_through t=%0t act=%b required no H&L pair", $time, act_word());
            end
            if (!nRst) begin
                compared++;
                if (act_word() !== 10'd0) begin
                    mismatched++;
                    $display("FAIL reset_state t=%0t act=%b required 0", $time, act_word());
                end
            end else if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL queue_empty t=%0t act=%b required model entry", $time, act_word());
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                compared++;
                if (act_word() !== e) begin
                    mismatched++;
                    $display("FAIL cycle t=%0t act=%b required=%b (gates,idx,pulse)", $time, act_word(), e);
                end
            end
        end
    end

    task automatic run(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 nRst = 1'b0;
        #1;
        compared++;
        if (act_word() !== 10'd0) begin
            mismatched++;
            $display("FAIL async_clear t=%0t act=%b required 0", $time, act_word());
        end
        @(negedge clk);
        @(negedge clk);
        #1 nRst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 nRst = 1'b1;
        @(posedge clk);
        #1;
        // defaults through the first step advance
        run(17000);
        power = 8'd8;
        run(1100);
        power = 8'hFF;
        run(1100);
        power = 8'h10;
        run(700);
        len_w = 12'd256;
        run(1500);
        // restart with a clamped step period
        en = 1'b0;
        speed = 25'd3;
        run(3);
        en = 1'b1;
        run(120);
        speed = 25'd40;
        len_w = 12'd16;
        mask = 12'd2;
        power = 8'h80;
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(63);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(150);
        pulse_reset();
        run(200);
        for (int i = 0; i < 20; i++) begin
            int n;
            speed = 25'($urandom_range(0, 600));
            power = 8'($urandom);
            len_w = 12'($urandom_range(0, 300));
            case ($urandom_range(0, 3))
                0: mask = 12'd0;
                1: mask = 12'($urandom_range(0, 8));
                2: mask = 12'($urandom_range(0, 40));
                default: mask = 12'($urandom_range(0, 300));
            endcase
            en = 1'b1;
            n = $urandom_range(200, 1500);
            run(n / 2);
            if ($urandom_range(0, 1) == 1) begin
                power = 8'($urandom);
                len_w = 12'($urandom_range(0, 300));
            end
            run(n / 2);
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 5));
            end
            if ($urandom_range(0, 4) == 0) pulse_reset();
        end
        run(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/motoro3_step_pwm_gen.md
Name: motoro3_step_pwm_gen

Overview:
Consumes the static drive settings from the motor register block: step period, power percent, PWM length and minimum-pulse mask. It produces the six registered gate-drive signals for a 3-phase, 6-step commutated motor. A step timer walks the commutation table. A PWM counter chops the active high-side switch, with a minimum-pulse rule and dead time at every commutation. It sits between the register block and the MOSFET driver pins.

Parameters:
DEAD_CLK, 4, clocks with all six gate outputs forced low after each step change and after leaving IDLE (10 MHz clk: 400 ns).
SPEED_MIN, 25'd8, lower clamp applied to the step period; must be ≥ DEAD_CLK+2.

Ports:
clk  input  1  system clock, 10 MHz
nRst  input  1  reset, asynchronous, active-low
m3r_stepCNT_speedSET  input  25  clocks per commutation step
m3r_power_percent  input  8  duty scale; on-time = pwmLen*power/256
m3r_pwmLenWant  input  12  PWM period in clocks
m3r_pwmMinMask  input  12  minimum on-pulse and minimum off-gap in clocks
m3_enable  input  1  run request; low = all gates off
m3_uH, m3_uL, m3_vH, m3_vL, m3_wH, m3_wL  output  1 each  gate drives, registered, active-high
m3_stepIdx  output  3  current commutation step, 0..5
m3_stepPulse  output  1  one-clock strobe on each step advance

Behaviour:
- Reset (async, nRst=0):
  - state=IDLE.
  - All gate outputs 0, m3_stepIdx=0, m3_stepPulse=0.
  - All counters and latches 0.
- State machine:
  - IDLE -> DEAD when m3_enable=1.
  - DEAD -> RUN after exactly DEAD_CLK clocks.
  - RUN -> DEAD on step-timer terminal count.
  - Any state -> IDLE when m3_enable=0, effective next clock; in IDLE the step index is reset to 0.
- Step timer:
  - 25-bit down counter.
  - Loaded on leaving IDLE and at each terminal count with speedL = max(m3r_stepCNT_speedSET, SPEED_MIN), sampled at load time.
  - Runs in both DEAD and RUN, so the step period is exactly speedL clocks, dead time included.
  - Terminal count: m3_stepIdx increments, wrapping 5 -> 0, and m3_stepPulse=1 for that one clock.
- PWM counter:
  - 12-bit, counts 0..lenL-1 and wraps.
  - Forced to 0 in IDLE and DEAD.
  - At count 0 the block latches lenL = max(m3r_pwmLenWant, 2).
  - At the same point it latches onL, computed as follows:
    - prod = (lenL × power)[19:0] >> 8.
    - If prod < minMask, onL = 0 (pulse suppressed).
    - Else if prod > lenL − minMask, onL = lenL − minMask, saturating at 0.
    - Otherwise onL = prod.
  - Input changes mid-period take effect at the next period start.
- High-side chop: pwmOn = (pwmCnt < onL), valid in RUN only.
- Commutation, as (PWM high side / static low side) per step:
  - step 0: U / V
  - step 1: U / W
  - step 2: V / W
  - step 3: V / U
  - step 4: W / U
  - step 5: W / V
  - All other gate outputs are 0.
- Outputs:
  - Gate outputs are registered: one clock of latency from state and counter.
  - In DEAD and IDLE all six are 0.
  - Invariant: xH & xL is never 1 for any phase, on any clock.
- Boundary cases:
  - power=0 gives no high-side pulses; the low side is still on in RUN.
  - minMask=0 disables both the suppression and the clamp.
  - minMask ≥ lenL/2 gives onL=0.

Test Plan:
1. Defaults: speed=16667, power=0x10, len=512, mask=32, enable=1.
   - Expect 4 clk of all-zero outputs, then step 0.
   - m3_uH is high 32 clk of every 512; m3_vL is steady 1.
   - Step advances every 16667 clk through 0..5 and wraps to 0; m3_stepPulse fires once per step.
2. power=8: prod=16<32, so m3_uH never asserts while the low side follows the table. power=0xFF: prod=510, clamped to 480, so m3_uH is high 480 of 512.
3. Commutation edge: all six outputs are 0 for exactly DEAD_CLK=4 clk after each stepPulse. A continuous assertion checks that no phase ever has H and L both high.
4. m3r_pwmLenWant changed 512 -> 256 mid-period: the current period completes at 512, and the next period is 256 with on-time 16 (below mask 32, so 0).
5. speed=3: clamped to SPEED_MIN=8, giving a step period of 8 clk.
6. m3_enable dropped mid-step, then nRst pulsed mid-RUN:
   - Enable low: outputs are 0 the next clk and stepIdx=0.
   - nRst low: outputs clear immediately, asynchronously.
   - After re-enable, the sequence restarts at step 0 after 4 dead clocks.
